// File: rtl/mcd_wr_data_conv_pkg.sv
// Shared definitions for the memcached write-data converter.
//   - MCD_CNT_W        : width of a 32-bit-word count (num_words, rem, pad)
//   - MCD_SECTOR_WORDS : 32-bit words per 512-byte sector
//   - wr_state_e       : converter state encoding
//   - pad_words()      : zero words needed to round a count up to a whole sector
package mcd_wr_data_conv_pkg;

    localparam int unsigned MCD_CNT_W        = 16;
    localparam int unsigned MCD_SECTOR_WORDS = 128;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFetch,
        StLo,
        StHi,
        StPad,
        StDone
    } wr_state_e;

    // Pure 16-bit unsigned arithmetic so the result matches the sector count
    // the command path derives from the same num_words.
    function automatic logic [MCD_CNT_W-1:0] pad_words(input logic [MCD_CNT_W-1:0] n,
                                                       input logic [MCD_CNT_W-1:0] sw);
        return (sw - (n % sw)) % sw;
    endfunction

endpackage

// File: rtl/mcd_len_fifo.sv
// Small synchronous FIFO holding pending transfer lengths.
//   clk, nReset : clock, synchronous active-low reset
//   push, din   : write strobe and data (ignored while full)
//   pop, dout   : read strobe and head-of-queue data (ignored while empty)
//   empty, full : occupancy flags
// A push and a pop in the same cycle are both honoured.
module mcd_len_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mcd_wr_data_conv.sv
// Memcached write-data converter: 64-bit memcached beats in, 32-bit HBA write
// words out, zero-padded to a whole number of sectors per write.
//   clk, nReset            : clock, synchronous active-low reset
//   num_words, wr_num_words_en : length of the next write (queued)
//   mem_data/valid/ready   : 64-bit memcached write-data stream
//   hba_wdata/wvalid/wready: 32-bit HBA write-data stream
//   busy                   : transfer in progress
//   wr_done                : one-cycle pulse after the last padded word
//   len_ovf                : one-cycle pulse when a length was dropped (queue full)
module mcd_wr_data_conv
    import mcd_wr_data_conv_pkg::*;
#(
    parameter int unsigned LEN_DEPTH    = 4,
    parameter int unsigned SECTOR_WORDS = MCD_SECTOR_WORDS
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic [15:0] num_words,
    input  logic        wr_num_words_en,
    input  logic [63:0] mem_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    output logic [31:0] hba_wdata,
    output logic        hba_wvalid,
    input  logic        hba_wready,
    output logic        busy,
    output logic        wr_done,
    output logic        len_ovf
);

    wr_state_e            state_q, state_d;
    logic [MCD_CNT_W-1:0] rem_q, rem_d;
    logic [MCD_CNT_W-1:0] pad_q, pad_d;
    logic [63:0]          hold_q, hold_d;
    logic                 len_ovf_q;

    logic                 fifo_pop;
    logic [MCD_CNT_W-1:0] fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_full;

    mcd_len_fifo #(
        .WIDTH(MCD_CNT_W),
        .DEPTH(LEN_DEPTH)
    ) u_len_fifo (
        .clk   (clk),
        .nReset(nReset),
        .push  (wr_num_words_en),
        .din   (num_words),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign busy    = (state_q != StIdle);
    assign len_ovf = len_ovf_q;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            pad_q     <= '0;
            hold_q    <= '0;
            len_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            pad_q     <= pad_d;
            hold_q    <= hold_d;
            len_ovf_q <= wr_num_words_en & fifo_full;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        pad_d      = pad_q;
        hold_d     = hold_q;
        fifo_pop   = 1'b0;
        mem_ready  = 1'b0;
        hba_wvalid = 1'b0;
        hba_wdata  = '0;
        wr_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    // Latch the head as it leaves the queue; LOAD works from rem/pad.
                    fifo_pop = 1'b1;
                    rem_d    = fifo_dout;
                    pad_d    = pad_words(fifo_dout, MCD_CNT_W'(SECTOR_WORDS));
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                state_d = (rem_q == '0) ? StDone : StFetch;
            end
            StFetch: begin
                mem_ready = 1'b1;
                if (mem_valid) begin
                    hold_d  = mem_data;
                    state_d = StLo;
                end
            end
            StLo: begin
                hba_wvalid = 1'b1;
                hba_wdata  = hold_q[31:0];
                if (hba_wready) begin
                    rem_d = rem_q - MCD_CNT_W'(1);
                    if (rem_q == MCD_CNT_W'(1)) begin
                        // Odd count: the upper half of this beat is dropped.
                        state_d = (pad_q != '0) ? StPad : StDone;
                    end else begin
                        state_d = StHi;
                    end
                end
            end
            StHi: begin
                hba_wvalid = 1'b1;
                hba_wdata  = hold_q[63:32];
                // Prefetch the next beat alongside the upper word to keep one word per cycle.
                mem_ready  = hba_wready & (rem_q > MCD_CNT_W'(1));
                if (hba_wready) begin
                    rem_d = rem_q - MCD_CNT_W'(1);
                    if (rem_q == MCD_CNT_W'(1)) begin
                        state_d = (pad_q != '0) ? StPad : StDone;
                    end else if (mem_valid) begin
                        hold_d  = mem_data;
                        state_d = StLo;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StPad: begin
                hba_wvalid = 1'b1;
                if (hba_wready) begin
                    pad_d = pad_q - MCD_CNT_W'(1);
                    if (pad_q == MCD_CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                wr_done = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
